spi_tx_frame_buffer: RTL and testbench

SPI_TX_FRAME_BUFFER -- requirements
Module: spi_tx_frame_buffer

---
 rtl/spi_frame_pkg.sv | 16 +
 rtl/spi_edge_sync.sv | 27 ++
 rtl/spi_tx_frame_buffer.sv | 136 +++++++++++++
 tb/tb_spi_tx_frame_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// Shared constants and types for the SPI transmit frame buffer.
package spi_frame_pkg;

  localparam int FRAME_BYTES = 16;
  localparam int IDX_W       = 4;

  // Byte 0 carries the frame sequence number; byte 15 carries the optional checksum.
  localparam int SEQ_IDX  = 0;
  localparam int CSUM_IDX = 15;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Three-stage synchroniser with level and edge detection for an asynchronous
// SPI pin (SS today, SCK later). Bit 0 is the newest sample.
module spi_edge_sync #(
  parameter logic [2:0] RST_VAL = 3'b111
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;

  // Shift the raw pin in; the reset value sets the idle level of the line.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) r_sync <= RST_VAL;
    else     r_sync <= {r_sync[1:0], i_sig};
  end

  assign o_level = r_sync[1];
  assign o_rise  = (r_sync[2:1] == 2'b01);
  assign o_fall  = (r_sync[2:1] == 2'b10);

endmodule

// File: rtl/spi_tx_frame_buffer.sv
// Ping-pong frame buffer between a byte-stream source and an SPI slave.
// Byte 0 of each frame is a sequence number; banks swap only while SS is idle.
// Optional feature macro: FRAME_CHECKSUM_EN (byte 15 = mod-256 sum of bytes 0..14).
module spi_tx_frame_buffer #(
  parameter int FRAME_BYTES = spi_frame_pkg::FRAME_BYTES,
  parameter int IDX_W       = spi_frame_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             SS,
  input  logic [IDX_W-1:0] rd_index,
  output logic [7:0]       rd_data,
  output logic             frame_valid,
  output logic             stale
);

  import spi_frame_pkg::*;

`ifdef FRAME_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_PAY_IDX = IDX_W'(CSUM_IDX - 1);
`else
  localparam logic [IDX_W-1:0] LAST_PAY_IDX = IDX_W'(FRAME_BYTES - 1);
`endif

  wr_state_t        r_state;
  wr_state_t        w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_seq;
  logic             r_sel;        // bank currently served to the SPI side
  logic             r_frame_valid;
  logic             r_stale;
  logic [7:0]       r_bank [2][FRAME_BYTES];
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic w_wr_sel;
  logic w_in_ready;
  logic w_accept;
  logic w_swap;
  logic w_ss_idle;
  logic w_ss_rise;
  logic w_ss_fall_unused;

  spi_edge_sync #(.RST_VAL(3'b111)) u_ss_sync (
    .clk     (clk),
    .rst     (rst),
    .i_sig   (SS),
    .o_level (w_ss_idle),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall_unused)
  );

  assign w_wr_sel = ~r_sel;

  // Write-side state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  // Next state, handshake and swap decision.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    w_swap      = 1'b0;
    case (r_state)
      FILL: begin
        w_in_ready = 1'b1;
        w_accept   = in_valid;
        if (in_valid && (r_idx == LAST_PAY_IDX)) w_state_nxt = FULL;
      end
      FULL: begin
        // Only exchange banks between SPI transactions.
        if (w_ss_idle) begin
          w_swap      = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Bank storage, fill index, sequence number, checksum and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the banks are explicitly cleared because a reset must never expose an old frame.
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < FRAME_BYTES; i++) r_bank[b][i] <= 8'h00;
      end
      r_idx         <= IDX_W'(1);
      r_seq         <= 8'h00;
      r_sel         <= 1'b0;
      r_frame_valid <= 1'b0;
      r_stale       <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_csum        <= 8'h00;
`endif
    end else begin
      if (w_accept) begin
        r_bank[w_wr_sel][r_idx] <= in_data;
        r_idx                   <= r_idx + IDX_W'(1);
`ifdef FRAME_CHECKSUM_EN
        r_csum <= r_csum + in_data;
        if (r_idx == LAST_PAY_IDX) r_bank[w_wr_sel][CSUM_IDX] <= r_csum + in_data;
`endif
      end

      if (w_swap) begin
        // The old read bank becomes the new write bank, pre-stamped with the next sequence.
        r_sel                  <= ~r_sel;
        r_bank[r_sel][SEQ_IDX] <= r_seq + 8'd1;
        r_seq                  <= r_seq + 8'd1;
        r_idx                  <= IDX_W'(1);
        r_frame_valid          <= 1'b1;
        r_stale                <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
        r_csum                 <= r_seq + 8'd1;
`endif
      end else if (w_ss_rise && r_frame_valid) begin
        r_stale <= 1'b1;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign frame_valid = r_frame_valid;
  assign stale       = r_stale;
  assign rd_data     = r_frame_valid ? r_bank[r_sel][rd_index] : 8'h00;

endmodule

// File: tb/tb_spi_tx_frame_buffer.sv
// Self-checking bench for spi_tx_frame_buffer: directed sequence with random
// payloads compared against a frame-level reference model.
module tb_spi_tx_frame_buffer;

`ifdef FRAME_CHECKSUM_EN
  localparam int NPAY = 14;
`else
  localparam int NPAY = 15;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       SS;
  logic [3:0] rd_index;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic       stale;

  int vectors = 0;
  int errs    = 0;

  // Reference model: frame-level view of what the SPI side should see.
  logic [7:0] m_read [16];
  logic [7:0] m_pend [$];
  logic [7:0] m_seq;
  logic       m_valid;
  logic       m_stale;

  spi_tx_frame_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .SS          (SS),
    .rd_index    (rd_index),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_read[i] = 8'h00;
    m_pend.delete();
    m_seq   = 8'h00;
    m_valid = 1'b0;
    m_stale = 1'b0;
  endtask

  // A swap publishes {seq, payload, [checksum]} and clears stale.
  task automatic model_swap();
    logic [7:0] sum;
    for (int i = 0; i < 16; i++) m_read[i] = 8'h00;
    m_read[0] = m_seq;
    for (int i = 0; i < NPAY; i++) m_read[i + 1] = m_pend[i];
`ifdef FRAME_CHECKSUM_EN
    sum = 8'h00;
    for (int i = 0; i < 15; i++) sum = sum + m_read[i];
    m_read[15] = sum;
`else
    sum = 8'h00;
`endif
    for (int i = 0; i < NPAY; i++) void'(m_pend.pop_front());
    m_seq   = m_seq + 8'd1;
    m_valid = 1'b1;
    m_stale = 1'b0;
  endtask

  // Sweeps rd_index within one clock low/high window (reads are combinational).
  task automatic check_frame(input string tag);
    check({tag, ".valid"}, {7'd0, frame_valid}, {7'd0, m_valid});
    check({tag, ".stale"}, {7'd0, stale}, {7'd0, m_stale});
    for (int i = 0; i < 16; i++) begin
      rd_index = 4'(i);
      #1;
      check($sformatf("%s.byte%0d", tag, i), rd_data, m_valid ? m_read[i] : 8'h00);
    end
  endtask

  // Pushes n bytes (ramp 1,2,3.. or random); each handshake bounded.
  task automatic write_bytes(input int n, input bit ramp);
    for (int k = 0; k < n; k++) begin
      int guard;
      logic [7:0] b;
      b        = ramp ? 8'(k + 1) : 8'($urandom);
      in_data  = b;
      in_valid = 1'b1;
      guard    = 0;
      while (in_ready !== 1'b1 && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) check("write.ready_timeout", {7'd0, in_ready}, 8'h01);
      tick();
      m_pend.push_back(b);
    end
    in_valid = 1'b0;
  endtask

  // Waits for in_ready to return after FULL; returns the cycles taken.
  task automatic wait_swap(input string tag, input int bound, output int cycles);
    cycles = 0;
    while (in_ready !== 1'b1 && cycles < bound) begin
      tick();
      cycles++;
    end
    check({tag, ".swap_seen"}, {7'd0, in_ready}, 8'h01);
  endtask

  task automatic ss_pulse();
    SS = 1'b0;
    repeat (5) tick();
    SS = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    int cyc;
    rst      = 1'b1;
    SS       = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    rd_index = 4'd0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state.
    check("rst.in_ready", {7'd0, in_ready}, 8'h01);
    check_frame("rst");

    // First frame with ramp payload; swap shortly after the last accept.
    write_bytes(NPAY, 1'b1);
    check("f0.in_ready_full", {7'd0, in_ready}, 8'h00);
    wait_swap("f0", 8, cyc);
    check("f0.latency_le4", {7'd0, cyc <= 4}, 8'h01);
    model_swap();
    rd_index = 4'd15;
    #1;
`ifdef FRAME_CHECKSUM_EN
    check("f0.byte15_const", rd_data, 8'h69);
`else
    check("f0.byte15_const", rd_data, 8'h0F);
`endif
    rd_index = 4'd0;
    #1;
    check("f0.seq_const", rd_data, 8'h00);
    check_frame("f0");

    // SS held low: frame completes but no swap; in_valid held in FULL is not consumed.
    SS = 1'b0;
    repeat (4) tick();
    write_bytes(NPAY, 1'b0);
    in_data  = 8'hA5;
    in_valid = 1'b1;
    repeat (6) tick();
    check("hold.in_ready", {7'd0, in_ready}, 8'h00);
    check_frame("hold");
    // Release SS: ss_rise and the swap coincide, so stale stays clear.
    SS = 1'b1;
    wait_swap("rel", 8, cyc);
    model_swap();
    tick();
    m_pend.push_back(8'hA5);
    in_valid = 1'b0;
    rd_index = 4'd0;
    #1;
    check("rel.seq_const", rd_data, 8'h01);
    check_frame("rel");

    // Two transactions without a new frame: stale after the first rise, data unchanged.
    ss_pulse();
    if (m_valid) m_stale = 1'b1;
    check_frame("stale1");
    ss_pulse();
    check_frame("stale2");

    // Complete the frame started with 0xA5; swap clears stale.
    write_bytes(NPAY - 1, 1'b0);
    wait_swap("f2", 8, cyc);
    model_swap();
    check_frame("f2");

    // Reset mid-fill discards the partial frame and restarts the sequence.
    write_bytes(7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("midrst.in_ready", {7'd0, in_ready}, 8'h01);
    check_frame("midrst");
    write_bytes(NPAY, 1'b0);
    wait_swap("postrst", 8, cyc);
    model_swap();
    check_frame("postrst");

    // 256 more frames: sequence walks 1..255 and wraps to 0.
    for (int f = 0; f < 256; f++) begin
      int ri;
      write_bytes(NPAY, 1'b0);
      wait_swap("wrap", 8, cyc);
      model_swap();
      ri = $urandom_range(1, 15);
      rd_index = 4'd0;
      #1;
      check($sformatf("wrap%0d.seq", f), rd_data, m_read[0]);
      rd_index = 4'(ri);
      #1;
      check($sformatf("wrap%0d.byte%0d", f, ri), rd_data, m_read[ri]);
      rd_index = 4'd15;
      #1;
      check($sformatf("wrap%0d.byte15", f), rd_data, m_read[15]);
    end
    rd_index = 4'd0;
    #1;
    check("wrap.final_seq_const", rd_data, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
